// File: rtl/traffic_request_encoder.sv
// Turns raw detector and pedestrian inputs into a one-at-a-time request code for
// the light controller. Inputs are synchronized and debounced, then latched as pending.
module traffic_request_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       en,
   input  logic       det_ns,
   input  logic       det_ew,
   input  logic       ped_btn,
   input  logic [3:0] grant,
   output logic [1:0] req,
   output logic       stuck
);

   localparam int DW = $clog2(DEB_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

   localparam logic [1:0] REQ_NONE = 2'b00;
   localparam logic [1:0] REQ_NS   = 2'b01;
   localparam logic [1:0] REQ_EW   = 2'b10;
   localparam logic [1:0] REQ_PED  = 2'b11;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   // Bit index 0 = NS, 1 = EW, 2 = pedestrian throughout.
   logic [2:0]    raw, sync1, sync2, fire, clr, pend;
   logic [DW-1:0] deb_cnt [3];
   logic [TW-1:0] tcnt;
   logic [1:0]    sel_code;
   logic          code_pend;
   logic          last_ew;
   state_t        state;

   assign raw = {ped_btn, det_ew, det_ns};
   assign clr = {grant == 4'b0000, grant[1], grant[3]};

   // An event fires only on the edge the counter climbs to DEB_CYCLES, so a held
   // input produces exactly one event until it drops low again.
   always_comb begin
      fire = '0;
      for (int i = 0; i < 3; i++)
         fire[i] = sync2[i] && (deb_cnt[i] == DEB_LAST);
   end

   // NOTE: the debounce counters are a handful of flops, not a RAM, so resetting
   // them in the loop costs nothing and keeps event timing defined after reset.
   always_ff @(posedge clk or posedge res_n) begin
      if (res_n) begin
         sync1 <= '0;
         sync2 <= '0;
         pend  <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else if (en) begin
         // NOTE: non-blocking assignments give both synchronizer stages the old
         // value of the stage before them, which is what makes this two flops.
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 3; i++) begin
            if (!sync2[i])
               deb_cnt[i] <= '0;
            else if (deb_cnt[i] != DEB_MAX)
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
         end
         pend <= (pend | fire) & ~clr;
      end
   end

   // NOTE: every signal in these combinational blocks gets a default first so
   // no path through the if/case leaves it holding a value (no latch).
   always_comb begin
      sel_code = REQ_NONE;
      if (pend[2])
         sel_code = REQ_PED;
      else if (pend[0] && pend[1])
         sel_code = last_ew ? REQ_NS : REQ_EW;
      else if (pend[0])
         sel_code = REQ_NS;
      else if (pend[1])
         sel_code = REQ_EW;
   end

   always_comb begin
      code_pend = 1'b0;
      case (req)
         REQ_NS:  code_pend = pend[0];
         REQ_EW:  code_pend = pend[1];
         REQ_PED: code_pend = pend[2];
         default: code_pend = 1'b0;
      endcase
   end

   // req doubles as the latched code: it is only non-zero while in SHOW.
   always_ff @(posedge clk or posedge res_n) begin
      if (res_n) begin
         state   <= IDLE;
         req     <= REQ_NONE;
         last_ew <= 1'b1;
         tcnt    <= '0;
         stuck   <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               if (|pend) begin
                  state <= SHOW;
                  req   <= sel_code;
                  tcnt  <= '0;
               end
            end
            SHOW: begin
               if (tcnt != TO_MAX) tcnt <= tcnt + 1'b1;
               if (tcnt == TO_LAST) stuck <= 1'b1;
               if (!code_pend) begin
                  state <= GAP;
                  req   <= REQ_NONE;
                  if (req == REQ_NS)
                     last_ew <= 1'b0;
                  else if (req == REQ_EW)
                     last_ew <= 1'b1;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_traffic_request_encoder.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase, all compared every cycle against a cycle-level behavioural model.
module tb_traffic_request_encoder;

   localparam int DEB = 4;
   localparam int TMO = 64;

   logic       clk;
   logic       res_n;
   logic       en;
   logic       det_ns;
   logic       det_ew;
   logic       ped_btn;
   logic [3:0] grant;
   logic [1:0] req;
   logic       stuck;

   int checks = 0;
   int errors = 0;

   traffic_request_encoder #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
      .clk     (clk),
      .res_n   (res_n),
      .en      (en),
      .det_ns  (det_ns),
      .det_ew  (det_ew),
      .ped_btn (ped_btn),
      .grant   (grant),
      .req     (req),
      .stuck   (stuck)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: index 0 NS, 1 EW, 2 pedestrian; phase 0 idle, 1 showing, 2 gap.
   int m_s1 [3];
   int m_s2 [3];
   int m_cnt [3];
   int m_pend [3];
   int m_phase;
   int m_code;
   int m_last;
   int m_t;
   int m_stuck;

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_pend[i] = 0;
      end
      m_phase = 0; m_code = 0; m_last = 2; m_t = 0; m_stuck = 0;
   endfunction

   function automatic void model_step();
      int raw [3];
      int clr [3];
      int old_pend [3];
      int new_cnt;
      raw = '{int'(det_ns), int'(det_ew), int'(ped_btn)};
      clr = '{int'(grant[3]), int'(grant[1]), int'(grant == 4'b0000)};
      for (int i = 0; i < 3; i++) begin
         old_pend[i] = m_pend[i];
         new_cnt = (m_s2[i] != 0) ? ((m_cnt[i] + 1 > DEB) ? DEB : m_cnt[i] + 1) : 0;
         if (new_cnt == DEB && m_cnt[i] != DEB) m_pend[i] = 1;
         if (clr[i] != 0) m_pend[i] = 0;
         m_cnt[i] = new_cnt;
         m_s2[i] = m_s1[i];
         m_s1[i] = raw[i];
      end
      case (m_phase)
         0: if (old_pend[0] + old_pend[1] + old_pend[2] > 0) begin
               if (old_pend[2] != 0)                         m_code = 3;
               else if (old_pend[0] != 0 && old_pend[1] != 0) m_code = (m_last == 2) ? 1 : 2;
               else if (old_pend[0] != 0)                     m_code = 1;
               else                                           m_code = 2;
               m_phase = 1;
               m_t = 0;
            end
         1: begin
               if (m_t < TMO) m_t++;
               if (m_t == TMO) m_stuck = 1;
               if (old_pend[m_code - 1] == 0) begin
                  m_phase = 2;
                  if (m_code != 3) m_last = m_code;
               end
            end
         default: m_phase = 0;
      endcase
   endfunction

   always @(posedge clk or posedge res_n) begin
      if (res_n) model_reset();
      else if (en) model_step();
   end

   always @(negedge clk) begin
      check("req_vs_model", {2'b00, req}, 4'((m_phase == 1) ? m_code : 0));
      check("stuck_vs_model", {3'b000, stuck}, 4'(m_stuck));
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Reset pulse between clock edges; the next posedge is edge 1 of a scenario.
   task automatic do_reset();
      @(negedge clk);
      #2 res_n = 1'b1;
      #1 res_n = 1'b0;
      en = 1'b1; det_ns = 1'b0; det_ew = 1'b0; ped_btn = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      res_n = 1'b1; en = 1'b0; det_ns = 1'b0; det_ew = 1'b0; ped_btn = 1'b0; grant = 4'b0000;
      edges(2);
      check("reset_req", {2'b00, req}, 4'h0);
      check("reset_stuck", {3'b000, stuck}, 4'h0);
      @(negedge clk);
      #2 res_n = 1'b0;

      // NS latency and grant clearing
      do_reset(); grant = 4'b0000; det_ns = 1'b1;
      edges(6);  check("lat_edge6", {2'b00, req}, 4'h0);
      edges(1);  check("lat_edge7", {2'b00, req}, 4'h1);
      grant = 4'b1000;
      edges(1);  check("ns_clear_hold", {2'b00, req}, 4'h1);
      edges(1);  check("ns_clear_gap", {2'b00, req}, 4'h0);
      det_ns = 1'b0;
      edges(3);

      // Short pulse never becomes an event
      do_reset(); grant = 4'b0000; det_ns = 1'b1;
      edges(3); det_ns = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edges(1); check("short_pulse", {2'b00, req}, 4'h0);
      end

      // NS and EW together: NS first, then EW after gap/idle
      do_reset(); grant = 4'b0000; det_ns = 1'b1; det_ew = 1'b1;
      edges(7);  check("both_ns_first", {2'b00, req}, 4'h1);
      grant = 4'b1000;
      edges(2);  check("both_gap", {2'b00, req}, 4'h0);
      edges(1);  check("both_idle", {2'b00, req}, 4'h0);
      edges(1);  check("both_ew_next", {2'b00, req}, 4'h2);
      grant = 4'b0010; det_ns = 1'b0; det_ew = 1'b0;
      edges(4);

      // Pedestrian beats EW, cleared by all-red
      do_reset(); grant = 4'b1000; ped_btn = 1'b1; det_ew = 1'b1;
      edges(7);  check("ped_first", {2'b00, req}, 4'h3);
      grant = 4'b0000;
      edges(2);  check("ped_cleared", {2'b00, req}, 4'h0);
      ped_btn = 1'b0; det_ew = 1'b0; grant = 4'b0010;
      edges(4);

      // Stuck timeout
      do_reset(); grant = 4'b1000; det_ew = 1'b1;
      n = 0;
      while (req !== 2'b10 && n < 20) begin
         edges(1); n++;
      end
      check("stuck_ew_show", {2'b00, req}, 4'h2);
      edges(63); check("stuck_before", {3'b000, stuck}, 4'h0);
      edges(1);  check("stuck_set", {3'b000, stuck}, 4'h1);
      check("stuck_req_held", {2'b00, req}, 4'h2);
      grant = 4'b0010; det_ew = 1'b0;
      edges(5);  check("stuck_sticky", {3'b000, stuck}, 4'h1);
      check("stuck_req_done", {2'b00, req}, 4'h0);

      // Enable freeze mid-debounce, then async reset during SHOW
      do_reset(); grant = 4'b0000; det_ns = 1'b1;
      edges(3); en = 1'b0;
      edges(10); en = 1'b1;
      edges(3);  check("freeze_edge6", {2'b00, req}, 4'h0);
      edges(1);  check("freeze_edge7", {2'b00, req}, 4'h1);
      #2 res_n = 1'b1;
      #1 check("async_reset_req", {2'b00, req}, 4'h0);
      check("async_reset_stuck", {3'b000, stuck}, 4'h0);
      res_n = 1'b0; det_ns = 1'b0;
      edges(2);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) det_ns = ~det_ns;
         if ($urandom_range(0, 11) == 0) det_ew = ~det_ew;
         if ($urandom_range(0, 15) == 0) ped_btn = ~ped_btn;
         if ($urandom_range(0, 5) == 0)  grant = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 res_n = 1'b1;
            #1 res_n = 1'b0;
         end
      end
      edges(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
